// File: rtl/nunchuk_pkg.sv
// Types and constants shared between the nunchuk driver and the cursor stage.
package nunchuk_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CALC   = 2'd1,
    UPDATE = 2'd2
  } cursor_state_t;

  localparam int         STICK_CENTER     = 128;
  localparam logic [6:0] NUNCHUK_I2C_ADDR = 7'h52;

endpackage

// File: rtl/button_debouncer.sv
// Debounce filter for one button. The raw level must disagree with the held level
// on DEBOUNCE consecutive enabled samples before the held level flips.
module button_debouncer #(
  parameter int DEBOUNCE = 3
) (
  input  logic clock,
  input  logic rst,
  input  logic en_i,
  input  logic raw_i,
  output logic held_o,
  output logic press_o
);

  localparam int CW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE - 1);

  logic          held_q, press_q;
  logic [CW-1:0] cnt_q;

  // The counter never passes LAST: reaching it on a differing sample flips and clears.
  always_ff @(posedge clock) begin
    if (rst) begin
      held_q  <= 1'b0;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      press_q <= 1'b0;
      if (en_i) begin
        if (raw_i == held_q) begin
          cnt_q <= '0;
        end else if (cnt_q == LAST) begin
          held_q  <= raw_i;
          press_q <= raw_i;
          cnt_q   <= '0;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
    end
  end

  assign held_o  = held_q;
  assign press_o = press_q;

endmodule

// File: rtl/nunchuk_cursor_ctrl.sv
// Turns nunchuk stick/button polls into a clamped, dead-zoned cursor position
// and debounced button levels/press pulses.
module nunchuk_cursor_ctrl
  import nunchuk_pkg::*;
#(
  parameter int SCREEN_W    = 640,
  parameter int SCREEN_H    = 480,
  parameter int CENTER      = STICK_CENTER,
  parameter int DEADZONE    = 16,
  parameter int SPEED_SHIFT = 3,
  parameter int DEBOUNCE    = 3,
  localparam int XW = $clog2(SCREEN_W),
  localparam int YW = $clog2(SCREEN_H)
) (
  input  logic          clock,
  input  logic          rst,
  input  logic          sample_valid_i,
  input  logic [7:0]    stick_x_i,
  input  logic [7:0]    stick_y_i,
  input  logic          z_i,
  input  logic          c_i,
  input  logic          recenter_i,
  output logic [XW-1:0] cursor_x_o,
  output logic [YW-1:0] cursor_y_o,
  output logic          z_held_o,
  output logic          c_held_o,
  output logic          z_press_o,
  output logic          c_press_o,
  output logic          update_strobe_o
);

  localparam logic signed [8:0]  CEN   = 9'(CENTER);
  localparam logic signed [8:0]  DZS   = 9'(DEADZONE);
  localparam logic        [8:0]  DZU   = 9'(DEADZONE);
  localparam logic signed [11:0] XMAX  = 12'(SCREEN_W - 1);
  localparam logic signed [11:0] YMAX  = 12'(SCREEN_H - 1);
  localparam logic [XW-1:0]      X_MID = XW'(SCREEN_W / 2);
  localparam logic [YW-1:0]      Y_MID = YW'(SCREEN_H / 2);

  cursor_state_t          state_q;
  logic [7:0]             sx_q, sy_q;
  logic                   z_q, c_q;
  logic signed [8:0]      vx_q, vy_q;
  logic [XW-1:0]          cx_q, cx_d;
  logic [YW-1:0]          cy_q, cy_d;
  logic                   strobe_q;
  logic signed [11:0]     nx, ny;

  // Arithmetic shift floors toward minus infinity, so negative speeds round away from zero.
  function automatic logic signed [8:0] axis_vel(input logic [7:0] s);
    logic signed [8:0] off, adj;
    logic        [8:0] mag;
    off = $signed({1'b0, s}) - CEN;
    mag = off[8] ? 9'(-off) : 9'(off);
    adj = off[8] ? (off + DZS) : (off - DZS);
    if (mag <= DZU) return '0;
    return adj >>> SPEED_SHIFT;
  endfunction

  always_comb begin
    nx   = $signed({{(12-XW){1'b0}}, cx_q}) + $signed({{3{vx_q[8]}}, vx_q});
    ny   = $signed({{(12-YW){1'b0}}, cy_q}) - $signed({{3{vy_q[8]}}, vy_q});
    cx_d = nx[XW-1:0];
    cy_d = ny[YW-1:0];
    if (nx[11])         cx_d = '0;
    else if (nx > XMAX) cx_d = XW'(SCREEN_W - 1);
    if (ny[11])         cy_d = '0;
    else if (ny > YMAX) cy_d = YW'(SCREEN_H - 1);
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      state_q  <= IDLE;
      sx_q     <= '0;
      sy_q     <= '0;
      z_q      <= 1'b0;
      c_q      <= 1'b0;
      vx_q     <= '0;
      vy_q     <= '0;
      cx_q     <= X_MID;
      cy_q     <= Y_MID;
      strobe_q <= 1'b0;
    end else begin
      strobe_q <= 1'b0;
      case (state_q)
        IDLE: if (sample_valid_i) begin
          sx_q    <= stick_x_i;
          sy_q    <= stick_y_i;
          z_q     <= z_i;
          c_q     <= c_i;
          state_q <= CALC;
        end
        CALC: begin
          vx_q    <= axis_vel(sx_q);
          vy_q    <= axis_vel(sy_q);
          state_q <= UPDATE;
        end
        UPDATE: begin
          cx_q     <= recenter_i ? X_MID : cx_d;
          cy_q     <= recenter_i ? Y_MID : cy_d;
          strobe_q <= 1'b1;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  button_debouncer #(.DEBOUNCE(DEBOUNCE)) u_z_db (
    .clock   (clock),
    .rst     (rst),
    .en_i    (state_q == UPDATE),
    .raw_i   (z_q),
    .held_o  (z_held_o),
    .press_o (z_press_o)
  );

  button_debouncer #(.DEBOUNCE(DEBOUNCE)) u_c_db (
    .clock   (clock),
    .rst     (rst),
    .en_i    (state_q == UPDATE),
    .raw_i   (c_q),
    .held_o  (c_held_o),
    .press_o (c_press_o)
  );

  assign cursor_x_o      = cx_q;
  assign cursor_y_o      = cy_q;
  assign update_strobe_o = strobe_q;

endmodule

// File: tb/tb_nunchuk_cursor_ctrl.sv
// Directed bench for nunchuk_cursor_ctrl with hand-computed expectations.
module tb_nunchuk_cursor_ctrl;

  logic       clock = 1'b0;
  logic       rst = 1'b1;
  logic       sample_valid = 1'b0;
  logic [7:0] stick_x = 8'd128, stick_y = 8'd128;
  logic       z = 1'b0, c = 1'b0, recenter = 1'b0;
  logic [9:0] cursor_x;
  logic [8:0] cursor_y;
  logic       z_held, c_held, z_press, c_press, update_strobe;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  nunchuk_cursor_ctrl dut (
    .clock           (clock),
    .rst             (rst),
    .sample_valid_i  (sample_valid),
    .stick_x_i       (stick_x),
    .stick_y_i       (stick_y),
    .z_i             (z),
    .c_i             (c),
    .recenter_i      (recenter),
    .cursor_x_o      (cursor_x),
    .cursor_y_o      (cursor_y),
    .z_held_o        (z_held),
    .c_held_o        (c_held),
    .z_press_o       (z_press),
    .c_press_o       (c_press),
    .update_strobe_o (update_strobe)
  );

  task automatic chk(input string tag, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", tag, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    rst = 1'b1;
    sample_valid = 1'b0;
    recenter = 1'b0;
    repeat (2) @(posedge clock);
    #1 rst = 1'b0;
  endtask

  // Presents one poll and returns #1 after the edge that publishes its result.
  task automatic sample(input logic [7:0] x, input logic [7:0] y,
                        input logic zb, input logic cb, input logic rc);
    @(negedge clock);
    stick_x = x; stick_y = y; z = zb; c = cb; recenter = rc;
    sample_valid = 1'b1;
    @(posedge clock);
    #1 sample_valid = 1'b0;
    repeat (2) @(posedge clock);
    #1;
  endtask

  initial begin
    int ex, ey, strobes;

    do_reset();
    chk("rst_x", cursor_x, 320);
    chk("rst_y", cursor_y, 240);
    chk("rst_strobe", update_strobe, 0);
    chk("rst_zheld", z_held, 0);
    chk("rst_cheld", c_held, 0);

    sample(8'd200, 8'd128, 0, 0, 0);
    chk("s200_strobe", update_strobe, 1);
    chk("s200_x", cursor_x, 327);
    chk("s200_y", cursor_y, 240);
    @(posedge clock); #1;
    chk("s200_strobe_off", update_strobe, 0);

    do_reset();
    sample(8'd20, 8'd128, 0, 0, 0);
    chk("s20_x", cursor_x, 308);
    sample(8'd140, 8'd128, 0, 0, 0);
    chk("dz_x", cursor_x, 308);
    chk("dz_y", cursor_y, 240);

    do_reset();
    ey = 240;
    for (int i = 0; i < 40; i++) begin
      sample(8'd128, 8'd200, 0, 0, 0);
      ey = (ey >= 7) ? ey - 7 : 0;
      chk($sformatf("up_y%0d", i), cursor_y, ey);
    end
    ex = 320;
    for (int i = 0; i < 30; i++) begin
      sample(8'd255, 8'd128, 0, 0, 0);
      ex = (ex + 13 > 639) ? 639 : ex + 13;
      chk($sformatf("right_x%0d", i), cursor_x, ex);
    end
    sample(8'd0, 8'd128, 0, 0, 0);
    chk("left_x", cursor_x, 625);

    do_reset();
    for (int i = 0; i < 2; i++) begin
      sample(8'd128, 8'd128, 1, 0, 0);
      chk($sformatf("z2_press%0d", i), z_press, 0);
      chk($sformatf("z2_held%0d", i), z_held, 0);
    end
    sample(8'd128, 8'd128, 0, 0, 0);
    chk("z0_held", z_held, 0);
    chk("z0_press", z_press, 0);
    sample(8'd128, 8'd128, 1, 0, 0);
    sample(8'd128, 8'd128, 1, 0, 0);
    chk("z3b_held", z_held, 0);
    sample(8'd128, 8'd128, 1, 0, 0);
    chk("z3_press", z_press, 1);
    chk("z3_held", z_held, 1);
    @(posedge clock); #1;
    chk("z3_press_off", z_press, 0);
    sample(8'd128, 8'd128, 1, 0, 0);
    chk("zhold_press", z_press, 0);
    chk("zhold_held", z_held, 1);

    do_reset();
    for (int i = 0; i < 3; i++) sample(8'd128, 8'd128, 1, 1, 0);
    chk("zc_zpress", z_press, 1);
    chk("zc_cpress", c_press, 1);
    chk("zc_cheld", c_held, 1);

    sample(8'd255, 8'd128, 1, 1, 0);
    chk("pre_rc_x", cursor_x, 333);
    sample(8'd255, 8'd0, 1, 1, 1);
    chk("rc_x", cursor_x, 320);
    chk("rc_y", cursor_y, 240);

    do_reset();
    @(negedge clock);
    stick_x = 8'd200; stick_y = 8'd128; z = 0; c = 0; recenter = 0;
    sample_valid = 1'b1;
    @(posedge clock);
    #1 stick_x = 8'd255;
    @(posedge clock);
    #1 sample_valid = 1'b0;
    strobes = 0;
    repeat (8) begin
      @(posedge clock); #1;
      if (update_strobe) strobes++;
    end
    chk("drop_strobes", strobes, 1);
    chk("drop_x", cursor_x, 327);

    do_reset();
    for (int i = 0; i < 3; i++) sample(8'd255, 8'd128, 1, 0, 0);
    chk("prerst_x", cursor_x, 359);
    chk("prerst_zheld", z_held, 1);
    @(negedge clock);
    sample_valid = 1'b1; stick_x = 8'd255;
    @(posedge clock);
    #1 sample_valid = 1'b0;
    @(negedge clock);
    rst = 1'b1;
    @(posedge clock); #1;
    chk("rstcalc_x", cursor_x, 320);
    chk("rstcalc_y", cursor_y, 240);
    chk("rstcalc_zheld", z_held, 0);
    chk("rstcalc_strobe", update_strobe, 0);
    rst = 1'b0;
    strobes = 0;
    repeat (5) begin
      @(posedge clock); #1;
      if (update_strobe) strobes++;
    end
    chk("rstcalc_nostrobe", strobes, 0);
    chk("rstcalc_x_after", cursor_x, 320);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
